tt_um_jleugeri_ttt_multi_processor: RTL and testbench

//   Multi-channel token processor core. CHANNELS independent channels share one

---
 rtl/tt_um_jleugeri_ttt_multi_processor.sv | 165 ++++++++++++++++
 tb/tb_tt_um_jleugeri_ttt_multi_processor.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_jleugeri_ttt_multi_processor.sv
// Multi-channel token processor: per-channel good/bad token counters with a round-robin
// scanner that emits start/end events. Optional REFRACTORY state under TTT_MULTI_REFRACTORY_EN.

module tt_um_jleugeri_ttt_multi_processor_channel #(
   parameter int NEW_TOKENS_BITS = 4,
   parameter int TOKENS_BITS     = 6,
   parameter int DURATION_BITS   = 4
)(
   input  logic                       clock_fast,
   input  logic                       reset,
   input  logic                       scan,
   input  logic                       upd,
   input  logic                       tick,
   input  logic [NEW_TOKENS_BITS-1:0] new_good_tokens,
   input  logic [NEW_TOKENS_BITS-1:0] new_bad_tokens,
   input  logic [TOKENS_BITS-1:0]     good_tokens_threshold,
   input  logic [TOKENS_BITS-1:0]     bad_tokens_threshold,
   input  logic [DURATION_BITS-1:0]   duration,
   output logic                       fire_start,
   output logic                       fire_end,
   output logic                       active
);
`ifdef TTT_MULTI_REFRACTORY_EN
   typedef enum logic [1:0] {IDLE, ACTIVE, REFRACTORY} state_t;
`else
   typedef enum logic [1:0] {IDLE, ACTIVE} state_t;
`endif
   localparam int TMAX = 2**TOKENS_BITS - 1;

   state_t                   state, state_n;
   logic [TOKENS_BITS-1:0]   good, good_n, bad, bad_n;
   logic [DURATION_BITS-1:0] rem, rem_n;
   int                       sum;

   always_ff @(posedge clock_fast or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         good  <= '0;
         bad   <= '0;
         rem   <= '0;
      end else begin
         state <= state_n;
         good  <= good_n;
         bad   <= bad_n;
         rem   <= rem_n;
      end
   end

   // Scan decisions use registered state; the token update then lands on top of any clear.
   always_comb begin
      state_n    = state;
      good_n     = good;
      bad_n      = bad;
      rem_n      = rem;
      sum        = 0;
      fire_start = scan && state == IDLE && good_tokens_threshold != '0 &&
                   good >= good_tokens_threshold;
      fire_end   = scan && state == ACTIVE && (rem == '0 ||
                   (bad_tokens_threshold != '0 && bad >= bad_tokens_threshold));
      if (tick && rem != '0 && state != IDLE) rem_n = rem - 1'b1;
      if (fire_start) begin
         state_n = ACTIVE;
         rem_n   = duration;
         good_n  = '0;
      end
      if (fire_end) begin
         bad_n = '0;
`ifdef TTT_MULTI_REFRACTORY_EN
         state_n = REFRACTORY;
         rem_n   = duration;
`else
         state_n = IDLE;
`endif
      end
`ifdef TTT_MULTI_REFRACTORY_EN
      if (scan && state == REFRACTORY && rem == '0) state_n = IDLE;
`endif
      if (upd) begin
         if (state == IDLE) begin
            sum = int'(good_n) + int'(new_good_tokens) - int'(new_bad_tokens);
            if (sum < 0) sum = 0;
            else if (sum > TMAX) sum = TMAX;
            good_n = TOKENS_BITS'(sum);
         end else if (state == ACTIVE) begin
            sum = int'(bad_n) + int'(new_bad_tokens);
            if (sum > TMAX) sum = TMAX;
            bad_n = TOKENS_BITS'(sum);
         end
      end
   end

   assign active = (state == ACTIVE);
endmodule

module tt_um_jleugeri_ttt_multi_processor #(
   parameter  int CHANNELS        = 4,
   parameter  int NEW_TOKENS_BITS = 4,
   parameter  int TOKENS_BITS     = 6,
   parameter  int DURATION_BITS   = 4,
   localparam int CH_BITS         = $clog2(CHANNELS)
)(
   input  logic                       clock_fast,
   input  logic                       reset,
   input  logic                       tick,
   input  logic                       in_valid,
   input  logic [CH_BITS-1:0]         in_channel,
   input  logic [NEW_TOKENS_BITS-1:0] new_good_tokens,
   input  logic [NEW_TOKENS_BITS-1:0] new_bad_tokens,
   input  logic [TOKENS_BITS-1:0]     good_tokens_threshold,
   input  logic [TOKENS_BITS-1:0]     bad_tokens_threshold,
   input  logic [DURATION_BITS-1:0]   duration,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [CH_BITS-1:0]         out_channel,
   output logic                       out_is_end,
   output logic [CHANNELS-1:0]        active
);
   logic [CH_BITS-1:0]  ptr;
   logic                stall;
   logic [CHANNELS-1:0] sel, fs, fe;

   assign stall = out_valid && !out_ready;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      assign sel[c] = !stall && ptr == CH_BITS'(c);
      tt_um_jleugeri_ttt_multi_processor_channel #(
         .NEW_TOKENS_BITS(NEW_TOKENS_BITS),
         .TOKENS_BITS    (TOKENS_BITS),
         .DURATION_BITS  (DURATION_BITS)
      ) u_ch (
         .clock_fast           (clock_fast),
         .reset                (reset),
         .scan                 (sel[c]),
         .upd                  (in_valid && in_channel == CH_BITS'(c)),
         .tick                 (tick),
         .new_good_tokens      (new_good_tokens),
         .new_bad_tokens       (new_bad_tokens),
         .good_tokens_threshold(good_tokens_threshold),
         .bad_tokens_threshold (bad_tokens_threshold),
         .duration             (duration),
         .fire_start           (fs[c]),
         .fire_end             (fe[c]),
         .active               (active[c])
      );
   end

   // Only the selected channel can fire, so OR-reducing the fire vectors is exact.
   always_ff @(posedge clock_fast or posedge reset) begin
      if (reset) begin
         ptr         <= '0;
         out_valid   <= 1'b0;
         out_channel <= '0;
         out_is_end  <= 1'b0;
      end else begin
         if (!stall) ptr <= (ptr == CH_BITS'(CHANNELS - 1)) ? '0 : ptr + 1'b1;
         if (|(fs | fe)) begin
            out_valid   <= 1'b1;
            out_channel <= ptr;
            out_is_end  <= |fe;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_tt_um_jleugeri_ttt_multi_processor.sv
// Bench for tt_um_jleugeri_ttt_multi_processor: vector table, directed corner sequences
// and a randomized run checked cycle-by-cycle against a behavioural model.
module tb_tt_um_jleugeri_ttt_multi_processor;
   localparam int CH = 4;
   localparam int TMAX = 63;

   logic       clock_fast = 0, reset = 0, tick = 0, in_valid = 0, out_ready = 1;
   logic [1:0] in_channel = 0;
   logic [3:0] new_good_tokens = 0, new_bad_tokens = 0, duration = 2;
   logic [5:0] good_tokens_threshold = 5, bad_tokens_threshold = 3;
   logic       out_valid, out_is_end;
   logic [1:0] out_channel;
   logic [3:0] active;

   int errors = 0, checks = 0;

   tt_um_jleugeri_ttt_multi_processor dut (
      .clock_fast(clock_fast), .reset(reset), .tick(tick), .in_valid(in_valid),
      .in_channel(in_channel), .new_good_tokens(new_good_tokens),
      .new_bad_tokens(new_bad_tokens), .good_tokens_threshold(good_tokens_threshold),
      .bad_tokens_threshold(bad_tokens_threshold), .duration(duration),
      .out_valid(out_valid), .out_ready(out_ready), .out_channel(out_channel),
      .out_is_end(out_is_end), .active(active));

   always #5 clock_fast = ~clock_fast;

   // Behavioural model: 0 idle, 1 active, 2 refractory.
   int m_st[CH], m_good[CH], m_bad[CH], m_rem[CH];
   int m_ptr, m_och;
   bit m_ov, m_oend;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         m_st[c] = 0; m_good[c] = 0; m_bad[c] = 0; m_rem[c] = 0;
      end
      m_ptr = 0; m_ov = 0; m_och = 0; m_oend = 0;
   endtask

   task automatic model_step();
      int st0[CH], good0[CH], bad0[CH], rem0[CH];
      int c;
      bit fired, fend;
      fired = 0; fend = 0;
      st0 = m_st; good0 = m_good; bad0 = m_bad; rem0 = m_rem;
      for (int k = 0; k < CH; k++)
         if (tick && rem0[k] > 0 && st0[k] != 0) m_rem[k] = rem0[k] - 1;
      c = m_ptr;
      if (!(m_ov && !out_ready)) begin
         if (st0[c] == 0 && good_tokens_threshold != 0 && good0[c] >= good_tokens_threshold) begin
            m_st[c] = 1; m_rem[c] = duration; m_good[c] = 0; fired = 1;
         end else if (st0[c] == 1 && (rem0[c] == 0 ||
                  (bad_tokens_threshold != 0 && bad0[c] >= bad_tokens_threshold))) begin
            fired = 1; fend = 1; m_bad[c] = 0;
`ifdef TTT_MULTI_REFRACTORY_EN
            m_st[c] = 2; m_rem[c] = duration;
`else
            m_st[c] = 0;
`endif
         end else if (st0[c] == 2 && rem0[c] == 0) begin
            m_st[c] = 0;
         end
         m_ptr = (m_ptr + 1) % CH;
      end
      if (fired) begin
         m_ov = 1; m_och = c; m_oend = fend;
      end else if (out_ready) m_ov = 0;
      if (in_valid && int'(in_channel) < CH) begin
         c = in_channel;
         if (st0[c] == 0) begin
            m_good[c] = m_good[c] + new_good_tokens - new_bad_tokens;
            if (m_good[c] < 0) m_good[c] = 0;
            if (m_good[c] > TMAX) m_good[c] = TMAX;
         end else if (st0[c] == 1) begin
            m_bad[c] = m_bad[c] + new_bad_tokens;
            if (m_bad[c] > TMAX) m_bad[c] = TMAX;
         end
      end
   endtask

   function automatic int model_active();
      int a = 0;
      for (int k = 0; k < CH; k++) if (m_st[k] == 1) a |= (1 << k);
      return a;
   endfunction

   // One clock: drive at negedge, model steps on the edge, compare at the next negedge.
   task automatic cyc(input logic iv, input int ch, input int ng, input int nb,
                      input logic tk, input logic rdy);
      in_valid = iv; in_channel = 2'(ch); new_good_tokens = 4'(ng);
      new_bad_tokens = 4'(nb); tick = tk; out_ready = rdy;
      @(posedge clock_fast);
      model_step();
      @(negedge clock_fast);
      chk("model_valid", out_valid, m_ov);
      if (m_ov) begin
         chk("model_channel", out_channel, m_och);
         chk("model_is_end", out_is_end, m_oend);
      end
      chk("model_active", active, model_active());
   endtask

   task automatic do_reset();
      in_valid = 0; tick = 0; out_ready = 1;
      reset = 1;
      model_reset();
      repeat (2) @(negedge clock_fast);
      reset = 0;
   endtask

   typedef struct {
      logic iv; int ch; int ng; int nb; logic tk;
      logic ev; int ech; logic eend; int eact;
   } vec_t;
   vec_t tbl[11];

   initial begin
      int cnt;
      tbl[0]  = '{1, 1, 3, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{1, 1, 3, 0, 0, 0, 0, 0, 0};
      tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[5]  = '{0, 0, 0, 0, 0, 1, 1, 0, 2};
      tbl[6]  = '{0, 0, 0, 0, 1, 0, 0, 0, 2};
      tbl[7]  = '{0, 0, 0, 0, 1, 0, 0, 0, 2};
      tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 2};
      tbl[9]  = '{0, 0, 0, 0, 0, 1, 1, 1, 0};
      tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

      @(negedge clock_fast);
      do_reset();
      chk("reset_valid", out_valid, 0);
      chk("reset_active", active, 0);
      chk("reset_channel", out_channel, 0);
      chk("reset_is_end", out_is_end, 0);

      // Start then duration-expiry end on ch1.
      for (int i = 0; i < 11; i++) begin
         cyc(tbl[i].iv, tbl[i].ch, tbl[i].ng, tbl[i].nb, tbl[i].tk, 1);
         chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
         if (tbl[i].ev) begin
            chk($sformatf("tbl%0d_channel", i), out_channel, tbl[i].ech);
            chk($sformatf("tbl%0d_is_end", i), out_is_end, tbl[i].eend);
         end
         chk($sformatf("tbl%0d_active", i), active, tbl[i].eact);
      end

`ifdef TTT_MULTI_REFRACTORY_EN
      cnt = 0;
      cyc(1, 1, 15, 0, 1, 1); cnt += out_valid;
      cyc(0, 0, 0, 0, 1, 1);  cnt += out_valid;
      repeat (4) begin cyc(0, 0, 0, 0, 0, 1); cnt += out_valid; end
      chk("refr_silent", cnt, 0);
      cyc(1, 1, 6, 0, 0, 1);
      for (int i = 0; i < 6 && !out_valid; i++) cyc(0, 0, 0, 0, 0, 1);
      chk("refr_start_valid", out_valid, 1);
      chk("refr_start_channel", out_channel, 1);
      chk("refr_start_is_end", out_is_end, 0);
`endif

      // Bad-token abort on ch2 before any tick.
      do_reset();
      cyc(1, 2, 6, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      chk("abort_start_valid", out_valid, 1);
      chk("abort_start_channel", out_channel, 2);
      chk("abort_start_is_end", out_is_end, 0);
      cyc(1, 2, 0, 1, 0, 1);
      cyc(1, 2, 0, 2, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      chk("abort_end_valid", out_valid, 1);
      chk("abort_end_channel", out_channel, 2);
      chk("abort_end_is_end", out_is_end, 1);
      chk("abort_end_active", active, 0);

      // Backpressure: ch0 start held, then ch2 start after accept.
      do_reset();
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(1, 0, 5, 0, 0, 0);
      cyc(1, 2, 5, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("bp_first_valid", out_valid, 1);
      chk("bp_first_channel", out_channel, 0);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("bp_held_valid", out_valid, 1);
      chk("bp_held_channel", out_channel, 0);
      chk("bp_held_active", active, 1);
      cyc(0, 0, 0, 0, 0, 1);
      chk("bp_accept_valid", out_valid, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("bp_second_valid", out_valid, 1);
      chk("bp_second_channel", out_channel, 2);
      chk("bp_second_is_end", out_is_end, 0);
      chk("bp_second_active", active, 5);

      // Asynchronous reset with an event pending.
      #2 reset = 1;
      #1;
      chk("areset_valid", out_valid, 0);
      chk("areset_active", active, 0);
      chk("areset_channel", out_channel, 0);
      model_reset();
      @(negedge clock_fast);
      reset = 0; out_ready = 1;

      // Saturation with starts disabled, then threshold probes of good=48.
      good_tokens_threshold = 0;
      repeat (5) cyc(1, 3, 15, 0, 0, 1);
      cyc(1, 3, 0, 15, 0, 1);
      good_tokens_threshold = 49;
      cnt = 0;
      repeat (8) begin cyc(0, 0, 0, 0, 0, 1); cnt += out_valid; end
      chk("sat_no_start_49", cnt, 0);
      good_tokens_threshold = 48;
      for (int i = 0; i < 6 && !out_valid; i++) cyc(0, 0, 0, 0, 0, 1);
      chk("sat_start_48_valid", out_valid, 1);
      chk("sat_start_48_channel", out_channel, 3);

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (i % 500 == 0) begin
            good_tokens_threshold = 6'($urandom_range(0, 40));
            bad_tokens_threshold  = 6'($urandom_range(0, 20));
            duration              = 4'($urandom_range(0, 5));
         end
         cyc($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 15),
             $urandom_range(0, 9), $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
